ahb_slave_pipe: RTL
===================

Name: ahb_slave_pipe

Overview:
- Parametrised successor to the bridge's AHB slave front end: decodes and qualifies AHB transfers, drives a multi-region peripheral select, and registers addr/data/write through a configurable-depth pipeline.
- Adds behaviour the current front end lacks: pipeline stall on hready_in=0, correct valid qualification, and a two-cycle AHB ERROR response for out-of-range transfers.
- Sits between the AHB interconnect and the bridge APB FSM; hr_data passes APB read data straight back to AHB.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- NUM_SEL, 3, number of peripheral regions (1..7).
- BASE_ADDR, 32'h8000_0000, start of region 0.
- REGION_SHIFT, 26, log2 of region size (64 MB regions).
- PIPE_DEPTH, 2, register stages for addr/data/write (1..4).

Ports:
- hclk  in  1  bridge clock.
- hreset  in  1  synchronous, active-low reset.
- hready_in  in  1  bus HREADY; transfer sampled and pipeline advances only when 1.
- hwrite  in  1  AHB write flag.
- htrans  in  2  AHB transfer type; IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- haddr  in  ADDR_W  AHB address.
- hwdata  in  DATA_W  AHB write data.
- pr_data  in  DATA_W  APB read data.
- haddr_pipe  out  PIPE_DEPTH*ADDR_W  stage k in slice k (stage 0 = 1-cycle delayed).
- hwdata_pipe  out  PIPE_DEPTH*DATA_W  same layout.
- hwrite_pipe  out  PIPE_DEPTH  bit k = hwrite delayed k+1 stages.
- valid  out  1  combinational qualified transfer.
- valid_pipe  out  PIPE_DEPTH  valid delayed per stage.
- temp_sel  out  SEL_W=$clog2(NUM_SEL+1)  region index+1; 0 = no region.
- hr_data  out  DATA_W  equals pr_data (combinational).
- hready_out  out  1  slave HREADY.
- hresp  out  1  1 = ERROR.

Behaviour:
- Region: in_range = haddr >= BASE_ADDR and haddr < BASE_ADDR + (NUM_SEL << REGION_SHIFT). Compute the limit at ADDR_W+1 bits; no wrap-around aliasing.
- temp_sel = ((haddr - BASE_ADDR) >> REGION_SHIFT) + 1 when in_range, else 0. Combinational.
- active = htrans[1] (NONSEQ or SEQ).
- valid = hready_in & active & in_range & (state==IDLE). This explicitly corrects the old precedence: SEQ no longer bypasses range or hready.
- Pipeline:
  - When hready_in=1, stage0 <= inputs and stage k <= stage k-1, for addr, data, write and valid.
  - When hready_in=0, all stages hold.
  - hwdata is captured with its address-phase stage. Data-phase alignment is the APB FSM's responsibility.
- Error FSM, states IDLE, ERR1, ERR2:
  - IDLE -> ERR1 when hready_in & active & ~in_range.
  - ERR1: hresp=1, hready_out=0. Goes to ERR2 next cycle unconditionally.
  - ERR2: hresp=1, hready_out=1. Goes to IDLE next cycle.
  - IDLE: hresp=0, hready_out=1.
  - IDLE/BUSY htrans never errors, whatever the address.
  - valid is forced 0 in ERR1/ERR2.
  - A new transfer presented during ERR2 is ignored. The master must re-issue it after the ERROR, per AHB.
- Simultaneous events: an out-of-range transfer with hready_in=0 is not sampled, so no error is raised.
- Reset, when hreset=0 at a hclk edge:
  - All pipe stages clear to 0, including valid_pipe and hwrite_pipe.
  - State returns to IDLE, so hresp=0 and hready_out=1 from the next cycle.
  - This applies mid-error as well: reset aborts ERR1/ERR2.
- Latency: stage k output appears k+1 accepted (hready_in=1) cycles after the input.

Decomposition:
- Shared package ahb_bridge_pkg holds:
  - htrans encodings: HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ.
  - hresp encodings: HRESP_OKAY, HRESP_ERROR.
  - Error FSM state enum.
- One natural sub-module: ahb_pipe_stage, a single hold-able register of addr/data/write/valid. It is instantiated PIPE_DEPTH times via generate.

Test Plan:
- Write NONSEQ to haddr=32'h8400_0010, hwdata=32'hDEAD_BEEF, hready_in=1 -> valid=1, temp_sel=2; after 1 cycle stage0 holds addr and data; after 2 cycles stage1 holds them with valid_pipe=2'b11.
- SEQ to 32'h8C00_0000 (first out-of-range byte for NUM_SEL=3) -> valid=0, temp_sel=0; next cycle hresp=1, hready_out=0; following cycle hresp=1, hready_out=1; then OKAY.
- SEQ to 32'h7FFF_FFFC with hready_in=0 -> no error, pipeline holds previous contents unchanged for every stalled cycle.
- BUSY and IDLE htrans to 32'h8000_0000 -> valid=0, temp_sel=1, hresp=0.
- hreset=0 asserted during ERR1 -> next cycle state IDLE, hresp=0, hready_out=1, all pipes 0.
- Parameter sweep PIPE_DEPTH=4, NUM_SEL=7, address 32'h9800_0000 -> temp_sel=7, stage3 valid 4 accepted cycles later; pr_data=32'h1234_5678 -> hr_data=32'h1234_5678 same cycle.

Source files
------------

// File: rtl/ahb_bridge_pkg.sv
// Shared encodings for the AHB side of the AHB-to-APB bridge.
// Holds the AHB htrans and hresp encodings and the error-response state encoding.
package ahb_bridge_pkg;

  // htrans encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // hresp encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Error FSM states
  typedef logic [1:0] err_state_t;
  localparam err_state_t StIdle = 2'd0;
  localparam err_state_t StErr1 = 2'd1;
  localparam err_state_t StErr2 = 2'd2;

endpackage

// File: rtl/ahb_pipe_stage.sv
// One hold-able register stage of the AHB address-phase pipeline.
// Ports:
//   clk_i, rst_ni  - clock and synchronous active-low reset
//   en_i           - load enable; stage holds when 0
//   addr_i/data_i/write_i/valid_i - values to capture
//   addr_o/data_o/write_o/valid_o - registered values
module ahb_pipe_stage #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              write_i,
  input  logic              valid_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              write_o,
  output logic              valid_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              write_q, write_d;
  logic              valid_q, valid_d;

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    write_d = write_q;
    valid_d = valid_q;
    if (en_i) begin
      addr_d  = addr_i;
      data_d  = data_i;
      write_d = write_i;
      valid_d = valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      write_q <= write_d;
      valid_q <= valid_d;
    end
  end

  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign write_o = write_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ahb_slave_pipe.sv
// AHB slave front end: qualifies transfers, decodes the peripheral region,
// pipelines addr/data/write/valid and issues a two-cycle ERROR response for
// out-of-range transfers.
// Ports:
//   hclk, hreset (sync, active-low) - clock and reset
//   hready_in, hwrite, htrans, haddr, hwdata - AHB master side
//   pr_data / hr_data  - APB read data, passed straight through
//   haddr_pipe, hwdata_pipe, hwrite_pipe, valid_pipe - stage k in slice/bit k
//   valid    - combinational qualified transfer
//   temp_sel - region index + 1, 0 when no region
//   hready_out, hresp - slave response
module ahb_slave_pipe
  import ahb_bridge_pkg::*;
#(
  parameter int unsigned      ADDR_W       = 32,
  parameter int unsigned      DATA_W       = 32,
  parameter int unsigned      NUM_SEL      = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned      REGION_SHIFT = 26,
  parameter int unsigned      PIPE_DEPTH   = 2,
  localparam int unsigned     SEL_W        = $clog2(NUM_SEL + 1)
) (
  input  logic                         hclk,
  input  logic                         hreset,
  input  logic                         hready_in,
  input  logic                         hwrite,
  input  logic [1:0]                   htrans,
  input  logic [ADDR_W-1:0]            haddr,
  input  logic [DATA_W-1:0]            hwdata,
  input  logic [DATA_W-1:0]            pr_data,
  output logic [PIPE_DEPTH*ADDR_W-1:0] haddr_pipe,
  output logic [PIPE_DEPTH*DATA_W-1:0] hwdata_pipe,
  output logic [PIPE_DEPTH-1:0]        hwrite_pipe,
  output logic                         valid,
  output logic [PIPE_DEPTH-1:0]        valid_pipe,
  output logic [SEL_W-1:0]             temp_sel,
  output logic [DATA_W-1:0]            hr_data,
  output logic                         hready_out,
  output logic                         hresp
);

  localparam int unsigned AW1 = ADDR_W + 1;

  // Region bounds are one bit wider so the limit cannot wrap and alias low addresses.
  localparam logic [ADDR_W:0] BaseExt  = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] LimitExt = BaseExt + (AW1'(NUM_SEL) << REGION_SHIFT);

  logic              in_range;
  logic              active;
  logic [ADDR_W-1:0] region_idx;
  err_state_t        state_q, state_d;

  // Region decode
  assign in_range   = ({1'b0, haddr} >= BaseExt) && ({1'b0, haddr} < LimitExt);
  assign region_idx = (haddr - BASE_ADDR) >> REGION_SHIFT;
  assign temp_sel   = in_range ? (SEL_W'(region_idx) + SEL_W'(1)) : '0;

  assign active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  assign valid  = hready_in && active && in_range && (state_q == StIdle);

  assign hr_data = pr_data;

  // Error FSM. Transfers offered outside StIdle are dropped; the master re-issues them.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (hready_in && active && !in_range) state_d = StErr1;
      StErr1:  state_d = StErr2;
      StErr2:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hreset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign hresp      = (state_q == StIdle) ? HRESP_OKAY : HRESP_ERROR;
  assign hready_out = (state_q != StErr1);

  // Pipeline: every stage advances together on hready_in and holds otherwise.
  logic [ADDR_W-1:0] st_addr  [PIPE_DEPTH];
  logic [DATA_W-1:0] st_data  [PIPE_DEPTH];
  logic              st_write [PIPE_DEPTH];
  logic              st_valid [PIPE_DEPTH];

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              in_write;
    logic              in_valid;

    if (k == 0) begin : g_first
      assign in_addr  = haddr;
      assign in_data  = hwdata;
      assign in_write = hwrite;
      assign in_valid = valid;
    end else begin : g_next
      assign in_addr  = st_addr[k-1];
      assign in_data  = st_data[k-1];
      assign in_write = st_write[k-1];
      assign in_valid = st_valid[k-1];
    end

    ahb_pipe_stage #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_stage (
      .clk_i   (hclk),
      .rst_ni  (hreset),
      .en_i    (hready_in),
      .addr_i  (in_addr),
      .data_i  (in_data),
      .write_i (in_write),
      .valid_i (in_valid),
      .addr_o  (st_addr[k]),
      .data_o  (st_data[k]),
      .write_o (st_write[k]),
      .valid_o (st_valid[k])
    );

    assign haddr_pipe[k*ADDR_W +: ADDR_W]  = st_addr[k];
    assign hwdata_pipe[k*DATA_W +: DATA_W] = st_data[k];
    assign hwrite_pipe[k]                  = st_write[k];
    assign valid_pipe[k]                   = st_valid[k];
  end

endmodule
